// File: rtl/otter_pipe_hazard_ctrl.sv
// otter_pipe_hazard_ctrl: hazard, interlock and forwarding controller for the
// pipelined OTTER core. It keeps a shadow scoreboard of every in-flight writer
// past decode and derives the stall, flush, bubble and forwarding controls.
//
// Optional feature macro: OTTER_HZD_FWD_EN
//   defined   : operands are forwarded from the nearest matching stage; only a
//               load-use on a stage below LOAD_AVAIL interlocks.
//   undefined : forwarding selects are tied to 0; any pending writer interlocks.
//
// Ports:
//   CLK, RESET_N        core clock, synchronous active-low reset
//   de_*                decode-stage instruction fields
//   ex_branch_taken     EX redirects the PC
//   mem_wait            data memory not ready for the MEM-stage access
//   stall_front         hold PC, IF/DE register and DE
//   stall_back          hold EX, MEM and WB registers
//   flush_if_de         invalidate IF/DE on the next edge
//   fwd_sel_a/b         0 = register file, k = stage k result
//   stage_valid         valid bit per tracked stage (bit k-1 = stage k)
//   stall_cnt           saturating count of stall_front cycles
module otter_pipe_hazard_ctrl #(
  parameter int unsigned STAGES     = 3,
  parameter int unsigned LOAD_AVAIL = 2,
  parameter int unsigned REG_AW     = 5,
  parameter int unsigned CNT_W      = 16,
  localparam int unsigned FW_W      = $clog2(STAGES + 1)
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic              de_valid,
  input  logic [REG_AW-1:0] de_rs1,
  input  logic              de_rs1_used,
  input  logic [REG_AW-1:0] de_rs2,
  input  logic              de_rs2_used,
  input  logic [REG_AW-1:0] de_rd,
  input  logic              de_reg_write,
  input  logic              de_is_load,
  input  logic              ex_branch_taken,
  input  logic              mem_wait,
  output logic              stall_front,
  output logic              stall_back,
  output logic              flush_if_de,
  output logic [FW_W-1:0]   fwd_sel_a,
  output logic [FW_W-1:0]   fwd_sel_b,
  output logic [STAGES-1:0] stage_valid,
  output logic [CNT_W-1:0]  stall_cnt
);

  // Scoreboard: index k-1 holds tracked stage k
  logic [STAGES-1:0]             vld_q, vld_d;
  logic [STAGES-1:0]             wr_q, wr_d;
  logic [STAGES-1:0]             ld_q, ld_d;
  logic [STAGES-1:0][REG_AW-1:0] rd_q, rd_d;
  logic [CNT_W-1:0]              cnt_q, cnt_d;

  logic [FW_W-1:0] near_a, near_b;
  logic            ld_a, ld_b;
  logic            haz_a, haz_b;
  logic            br_c, sb_c, sf_c;

  // Nearest-match search; scanning from the oldest stage down lets the
  // youngest (smallest k) writer overwrite older ones. x0 never matches.
  always_comb begin
    near_a = '0;
    near_b = '0;
    ld_a   = 1'b0;
    ld_b   = 1'b0;
    for (int k = STAGES; k >= 1; k--) begin
      if (de_rs1_used && (de_rs1 != '0) && vld_q[k-1] && wr_q[k-1] &&
          (rd_q[k-1] == de_rs1)) begin
        near_a = FW_W'(k);
        ld_a   = ld_q[k-1];
      end
      if (de_rs2_used && (de_rs2 != '0) && vld_q[k-1] && wr_q[k-1] &&
          (rd_q[k-1] == de_rs2)) begin
        near_b = FW_W'(k);
        ld_b   = ld_q[k-1];
      end
    end
  end

`ifdef OTTER_HZD_FWD_EN
  // Only load data that is not yet available at its stage forces an interlock
  assign haz_a = (near_a != '0) && ld_a && (32'(near_a) < LOAD_AVAIL);
  assign haz_b = (near_b != '0) && ld_b && (32'(near_b) < LOAD_AVAIL);
  assign fwd_sel_a = RESET_N ? near_a : '0;
  assign fwd_sel_b = RESET_N ? near_b : '0;
`else
  // Without forwarding the register file is the only source, so any pending
  // writer interlocks until it has retired
  logic unused_fwd;
  assign unused_fwd = ld_a ^ ld_b;
  assign haz_a = (near_a != '0);
  assign haz_b = (near_b != '0);
  assign fwd_sel_a = '0;
  assign fwd_sel_b = '0;
`endif

  // A branch only counts when EX actually holds a valid instruction
  assign br_c = ex_branch_taken & vld_q[0];
  assign sb_c = mem_wait;
  // A taken branch squashes DE, so a load-use in DE must not stall it
  assign sf_c = sb_c | ((haz_a | haz_b) & ~br_c & de_valid);

  assign stall_back  = RESET_N & sb_c;
  assign stall_front = RESET_N & sf_c;
  // While the back end holds, the branch is deferred until mem_wait drops
  assign flush_if_de = ~RESET_N | (br_c & ~sb_c);

  assign stage_valid = vld_q;
  assign stall_cnt   = cnt_q;

  // Scoreboard advance / bubble insertion and stall counter next state
  always_comb begin
    vld_d = vld_q;
    wr_d  = wr_q;
    ld_d  = ld_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (!sb_c) begin
      for (int k = STAGES - 1; k >= 1; k--) begin
        vld_d[k] = vld_q[k-1];
        wr_d[k]  = wr_q[k-1];
        ld_d[k]  = ld_q[k-1];
        rd_d[k]  = rd_q[k-1];
      end
      vld_d[0] = de_valid & ~sf_c & ~br_c;
      wr_d[0]  = de_reg_write;
      ld_d[0]  = de_is_load;
      rd_d[0]  = de_rd;
    end
    if (sf_c && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // State registers; payload fields need no reset since valid gates them
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      vld_q <= '0;
      cnt_q <= '0;
    end else begin
      vld_q <= vld_d;
      wr_q  <= wr_d;
      ld_q  <= ld_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: tb/tb_otter_pipe_hazard_ctrl.sv
// Testbench for otter_pipe_hazard_ctrl: directed vector table, hand-written
// multi-cycle sequences and a randomized run against a reference model.
// Honours OTTER_HZD_FWD_EN the same way the design does.
module tb_otter_pipe_hazard_ctrl;

  localparam int unsigned STAGES     = 3;
  localparam int unsigned LOAD_AVAIL = 2;
  localparam int unsigned REG_AW     = 5;
  localparam int unsigned CNT_W      = 4;
  localparam int unsigned FW_W       = 2;
  localparam int          CNT_MAX    = 15;
`ifdef OTTER_HZD_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic              CLK;
  logic              RESET_N;
  logic              de_valid;
  logic [REG_AW-1:0] de_rs1;
  logic              de_rs1_used;
  logic [REG_AW-1:0] de_rs2;
  logic              de_rs2_used;
  logic [REG_AW-1:0] de_rd;
  logic              de_reg_write;
  logic              de_is_load;
  logic              ex_branch_taken;
  logic              mem_wait;
  logic              stall_front;
  logic              stall_back;
  logic              flush_if_de;
  logic [FW_W-1:0]   fwd_sel_a;
  logic [FW_W-1:0]   fwd_sel_b;
  logic [STAGES-1:0] stage_valid;
  logic [CNT_W-1:0]  stall_cnt;

  otter_pipe_hazard_ctrl #(
    .STAGES(STAGES), .LOAD_AVAIL(LOAD_AVAIL), .REG_AW(REG_AW), .CNT_W(CNT_W)
  ) dut (
    .CLK(CLK), .RESET_N(RESET_N), .de_valid(de_valid),
    .de_rs1(de_rs1), .de_rs1_used(de_rs1_used),
    .de_rs2(de_rs2), .de_rs2_used(de_rs2_used),
    .de_rd(de_rd), .de_reg_write(de_reg_write), .de_is_load(de_is_load),
    .ex_branch_taken(ex_branch_taken), .mem_wait(mem_wait),
    .stall_front(stall_front), .stall_back(stall_back), .flush_if_de(flush_if_de),
    .fwd_sel_a(fwd_sel_a), .fwd_sel_b(fwd_sel_b),
    .stage_valid(stage_valid), .stall_cnt(stall_cnt)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", nm, got, exp);
    end
  endtask

  typedef struct {
    bit rst; bit dv; int rs1; bit u1; int rs2; bit u2; int rd; bit wr; bit ld;
    bit br; bit mw;
    bit sf; bit sb; bit fl; int fa; int fb; int sv; int cnt;
  } vec_t;
  vec_t tbl[$];

  function automatic vec_t mk(input bit rst, dv, input int rs1, input bit u1,
                              input int rs2, input bit u2, input int rd,
                              input bit wr, ld, br, mw, sf, sb, fl,
                              input int fa, fb, sv, cnt);
    vec_t v;
    v = '{rst, dv, rs1, u1, rs2, u2, rd, wr, ld, br, mw, sf, sb, fl, fa, fb, sv, cnt};
    return v;
  endfunction

  task automatic drive(input bit rst, dv, input int rs1, input bit u1,
                       input int rs2, input bit u2, input int rd,
                       input bit wr, ld, br, mw);
    RESET_N         = rst;
    de_valid        = dv;
    de_rs1          = REG_AW'(rs1);
    de_rs1_used     = u1;
    de_rs2          = REG_AW'(rs2);
    de_rs2_used     = u2;
    de_rd           = REG_AW'(rd);
    de_reg_write    = wr;
    de_is_load      = ld;
    ex_branch_taken = br;
    mem_wait        = mw;
  endtask

  task automatic tick();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  // Reference model: pipe[0] is the instruction in EX, pipe[STAGES-1] in WB
  typedef struct { bit v; int rd; bit wr; bit ld; } ent_t;
  ent_t pipe[STAGES];
  int   m_cnt;
  bit   m_sf, m_sb, m_fl, m_br;
  int   m_fa, m_fb;

  function automatic int nearest(input int src, input bit used);
    if (!used || src == 0) return 0;
    for (int k = 0; k < STAGES; k++)
      if (pipe[k].v && pipe[k].wr && pipe[k].rd == src) return k + 1;
    return 0;
  endfunction

  function automatic bit is_hazard(input int n);
    if (n == 0) return 1'b0;
    if (!FWD) return 1'b1;
    return pipe[n-1].ld && (n < int'(LOAD_AVAIL));
  endfunction

  // Raw (unforced) model values kept in m_sf/m_sb/m_br for the clock update
  task automatic model_eval();
    int na, nb;
    na   = nearest(int'(de_rs1), de_rs1_used);
    nb   = nearest(int'(de_rs2), de_rs2_used);
    m_br = ex_branch_taken && pipe[0].v;
    m_sb = mem_wait;
    m_sf = m_sb || ((is_hazard(na) || is_hazard(nb)) && !m_br && de_valid);
    m_fl = m_br && !m_sb;
    m_fa = FWD ? na : 0;
    m_fb = FWD ? nb : 0;
  endtask

  task automatic model_clock();
    if (!RESET_N) begin
      foreach (pipe[k]) pipe[k].v = 1'b0;
      m_cnt = 0;
    end else begin
      if (m_sf && m_cnt < CNT_MAX) m_cnt++;
      if (!m_sb) begin
        for (int k = STAGES - 1; k > 0; k--) pipe[k] = pipe[k-1];
        pipe[0] = '{de_valid && !m_sf && !m_br, int'(de_rd), de_reg_write, de_is_load};
      end
    end
  endtask

  function automatic int model_sv();
    int s = 0;
    for (int k = 0; k < STAGES; k++) if (pipe[k].v) s |= (1 << k);
    return s;
  endfunction

  initial begin
    int sv0;
    // Power-up reset edge before anything is checked
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();

`ifdef OTTER_HZD_FWD_EN
    tbl.push_back(mk(0,0, 0,0, 0,0,  0,0,0, 0,0,  0,0,1, 0,0, 0,0)); // reset forces
    tbl.push_back(mk(1,1, 1,1, 2,1,  5,1,0, 0,0,  0,0,0, 0,0, 0,0)); // add x5
    tbl.push_back(mk(1,1, 5,1, 0,0,  7,1,0, 0,0,  0,0,0, 1,0, 1,0)); // use x5 from EX
    tbl.push_back(mk(1,1, 5,1, 3,1,  8,1,0, 0,0,  0,0,0, 2,0, 3,0)); // use x5 from MEM
    tbl.push_back(mk(1,1, 1,1, 0,0,  6,1,1, 0,0,  0,0,0, 0,0, 7,0)); // lw x6
    tbl.push_back(mk(1,1, 2,1, 6,1,  9,1,0, 0,0,  1,0,0, 0,1, 7,0)); // load-use stall
    tbl.push_back(mk(1,1, 2,1, 6,1,  9,1,0, 0,0,  0,0,0, 0,2, 6,1)); // released, fwd MEM
    tbl.push_back(mk(1,1, 1,1, 0,0,  6,1,1, 0,0,  0,0,0, 0,0, 5,1)); // lw x6
    tbl.push_back(mk(1,1, 3,1, 4,1,  0,0,0, 0,0,  0,0,0, 0,0, 3,1)); // branch
    tbl.push_back(mk(1,1, 0,0, 6,1, 10,1,0, 1,0,  0,0,1, 0,2, 7,1)); // taken, flush
    tbl.push_back(mk(1,1, 1,1, 0,0, 11,1,0, 0,1,  1,1,0, 0,0, 6,1)); // mem_wait
    tbl.push_back(mk(1,1, 1,1, 0,0, 11,1,0, 0,0,  0,0,0, 0,0, 6,2)); // resume
    tbl.push_back(mk(1,1, 1,1, 0,0,  0,1,0, 0,0,  0,0,0, 0,0, 5,2)); // writes x0
    tbl.push_back(mk(1,1, 0,1, 0,1, 12,1,0, 0,0,  0,0,0, 0,0, 3,2)); // reads x0
    tbl.push_back(mk(0,1,12,1, 0,0,  0,0,0, 1,1,  0,0,1, 0,0, 7,2)); // reset overrides
    tbl.push_back(mk(1,0, 0,0, 0,0,  0,0,0, 0,0,  0,0,0, 0,0, 0,0)); // cleared
`else
    tbl.push_back(mk(0,0, 0,0, 0,0,  0,0,0, 0,0,  0,0,1, 0,0, 0,0)); // reset forces
    tbl.push_back(mk(1,1, 1,1, 2,1,  5,1,0, 0,0,  0,0,0, 0,0, 0,0)); // add x5
    tbl.push_back(mk(1,1, 5,1, 0,0,  7,1,0, 0,0,  1,0,0, 0,0, 1,0)); // x5 in EX
    tbl.push_back(mk(1,1, 5,1, 0,0,  7,1,0, 0,0,  1,0,0, 0,0, 2,1)); // x5 in MEM
    tbl.push_back(mk(1,1, 5,1, 0,0,  7,1,0, 0,0,  1,0,0, 0,0, 4,2)); // x5 in WB
    tbl.push_back(mk(1,1, 5,1, 0,0,  7,1,0, 0,0,  0,0,0, 0,0, 0,3)); // retired
    tbl.push_back(mk(1,1, 1,1, 0,0,  8,1,0, 1,1,  1,1,0, 0,0, 1,3)); // branch held
    tbl.push_back(mk(1,1, 1,1, 0,0,  8,1,0, 1,0,  0,0,1, 0,0, 1,4)); // deferred flush
    tbl.push_back(mk(1,1, 7,1, 0,0,  9,1,0, 1,0,  1,0,0, 0,0, 2,4)); // branch w/o EX valid
    tbl.push_back(mk(0,1, 7,1, 0,0,  9,1,0, 0,0,  0,0,1, 0,0, 4,5)); // reset mid-stall
    tbl.push_back(mk(1,0, 0,0, 0,0,  0,0,0, 0,0,  0,0,0, 0,0, 0,0)); // cleared
    tbl.push_back(mk(1,1, 1,1, 0,0,  0,1,0, 0,0,  0,0,0, 0,0, 0,0)); // writes x0
    tbl.push_back(mk(1,1, 0,1, 0,1,  3,1,0, 0,0,  0,0,0, 0,0, 1,0)); // reads x0
`endif

    foreach (tbl[i]) begin
      vec_t v;
      v = tbl[i];
      drive(v.rst, v.dv, v.rs1, v.u1, v.rs2, v.u2, v.rd, v.wr, v.ld, v.br, v.mw);
      #1;
      chk($sformatf("row%0d stall_front", i), int'(stall_front), int'(v.sf));
      chk($sformatf("row%0d stall_back", i),  int'(stall_back),  int'(v.sb));
      chk($sformatf("row%0d flush_if_de", i), int'(flush_if_de), int'(v.fl));
      chk($sformatf("row%0d fwd_sel_a", i),   int'(fwd_sel_a),   v.fa);
      chk($sformatf("row%0d fwd_sel_b", i),   int'(fwd_sel_b),   v.fb);
      chk($sformatf("row%0d stage_valid", i), int'(stage_valid), v.sv);
      chk($sformatf("row%0d stall_cnt", i),   int'(stall_cnt),   v.cnt);
      tick();
    end

    // Branch deferred by mem_wait: no flush and frozen scoreboard for 3 cycles
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    drive(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    sv0 = int'(stage_valid);
    chk("mw_br branch in EX", sv0, 1);
    for (int c = 0; c < 3; c++) begin
      drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
      #1;
      chk($sformatf("mw_br c%0d flush", c), int'(flush_if_de), 0);
      chk($sformatf("mw_br c%0d stage_valid", c), int'(stage_valid), sv0);
      tick();
    end
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    #1;
    chk("mw_br release flush", int'(flush_if_de), 1);
    tick();
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("mw_br one-shot flush", int'(flush_if_de), 0);
    chk("mw_br bubble behind branch", int'(stage_valid), 2);

    // Stall counter saturation
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    for (int c = 0; c < 20; c++) begin
      drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      tick();
    end
    chk("stall_cnt saturated", int'(stall_cnt), CNT_MAX);
    tick();
    chk("stall_cnt holds at max", int'(stall_cnt), CNT_MAX);

    // Randomized run against the reference model
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    foreach (pipe[k]) pipe[k] = '{1'b0, 0, 1'b0, 1'b0};
    m_cnt = 0;
    for (int c = 0; c < 3000; c++) begin
      drive($urandom_range(0, 99) != 0, $urandom_range(0, 9) < 8,
            $urandom_range(0, 3), $urandom_range(0, 1),
            $urandom_range(0, 3), $urandom_range(0, 1),
            $urandom_range(0, 3), $urandom_range(0, 3) != 0,
            $urandom_range(0, 2) == 0, $urandom_range(0, 6) == 0,
            $urandom_range(0, 4) == 0);
      #1;
      model_eval();
      chk($sformatf("rnd%0d stall_front", c), int'(stall_front), RESET_N ? int'(m_sf) : 0);
      chk($sformatf("rnd%0d stall_back", c),  int'(stall_back),  RESET_N ? int'(m_sb) : 0);
      chk($sformatf("rnd%0d flush_if_de", c), int'(flush_if_de), RESET_N ? int'(m_fl) : 1);
      chk($sformatf("rnd%0d fwd_sel_a", c),   int'(fwd_sel_a),   RESET_N ? m_fa : 0);
      chk($sformatf("rnd%0d fwd_sel_b", c),   int'(fwd_sel_b),   RESET_N ? m_fb : 0);
      chk($sformatf("rnd%0d stage_valid", c), int'(stage_valid), model_sv());
      chk($sformatf("rnd%0d stall_cnt", c),   int'(stall_cnt),   m_cnt);
      @(posedge CLK);
      model_clock();
      @(negedge CLK);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
